seq_mult_param: RTL and testbench
=================================

Name: seq_mult_param

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 4x4 combinational array multiplier.
- Replaces the partial-product array with a one-bit-per-cycle datapath and a start/done handshake.
- Adds a runtime signed/unsigned mode.
- Serves arithmetic datapaths that can tolerate fixed multi-cycle latency in exchange for area.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only when busy=0
signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; captured with start
a  input  WIDTH  multiplicand; captured with start
b  input  WIDTH  multiplier; captured with start
busy  output  1  high while a multiplication is in progress
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  result register; holds until the next completion or reset

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On a clk edge with rst=1: state=IDLE, busy=0, done=0, product=0, iteration counter=0. rst overrides start.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, for exactly one cycle.
- IDLE/DONE -> RUN on an edge with start=1:
  - Capture a, b, signed_mode.
  - In signed mode, store |a|, |b| as WIDTH-bit unsigned magnitudes. The most negative value maps to 2^(WIDTH-1), which fits.
  - Record neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator and set counter=0.
- DONE -> IDLE on an edge with start=0.
- DONE with start=1 goes straight to RUN, giving back-to-back operations with no idle cycle.
- RUN iteration, one per edge: if the multiplier LSB is 1, add the multiplicand, aligned at the upper WIDTH bits, into the accumulator. Then shift the accumulator right by 1 (carry-out enters at the MSB) and shift the multiplier right by 1. Counter increments each iteration.
- Iteration width rule: the adder is WIDTH+1 bits so the carry is kept; no bits are lost.
- RUN -> DONE on the edge completing iteration WIDTH (counter = WIDTH-1 at that edge). The same edge loads product with neg ? -acc : acc (two's complement, 2*WIDTH bits).
- Latency: start sampled at edge k -> done=1 and product valid in the cycle following edge k+WIDTH. Latency is fixed and independent of operand values, including zero.
- start while busy=1 is ignored: no capture, no restart, no error.
- product changes only on RUN->DONE or reset. The previous result stays readable during a new RUN.
- Unsigned mode: product = a*b exactly; max (2^W-1)^2 fits in 2W bits.
- Signed mode: product = a*b exactly. The (-2^(W-1))^2 = 2^(2W-2) case is positive and representable.
- Zero in signed mode: a zero result is +0 (negating 0 gives 0), so there is no negative-zero issue.
- Reset mid-RUN: the operation is aborted, no done pulse occurs, and product=0.
- Inputs a, b, signed_mode may change freely while busy=1 with no effect.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8, unsigned, a=13, b=11, start for 1 cycle -> busy high 8 cycles; done pulse 8 cycles after start is sampled; product=0x008F; busy=0 in the done cycle.
- WIDTH=8, unsigned, a=255, b=255 -> product=0xFE01. Then signed, a=0xFD (-3), b=0x05 -> product=0xFFF1 (-15).
- WIDTH=8, signed, a=0x80, b=0x80 -> product=0x4000. Signed, a=0x80, b=0x01 -> product=0xFF80. Signed, a=0x00, b=0x80 -> product=0x0000.
- Start a=3, b=4; pulse start again at cycle 3 with a=7, b=7 -> second request ignored; single done; product=0x000C. Then start held high in the done cycle with a=2, b=5 -> RUN entered with no idle gap; next product=0x000A.
- Complete 6*7 (product=0x002A); start 9*9, assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, product=0x0000; no done pulse for 9*9; a fresh start afterwards gives 0x0051.
- WIDTH=4 and WIDTH=16 builds: random unsigned/signed operands (1000 each) checked against a reference model. Latency must equal WIDTH cycles every time.

Source files
------------

// File: rtl/seq_mult_param.sv
// -----------------------------------------------------------------------------
// seq_mult_param
//
// Sequential shift-add multiplier. It handles one multiplier bit per clock, so
// a result takes exactly WIDTH cycles. A runtime mode selects signed
// (two's-complement) or unsigned operands.
//
// Signed operands are converted to unsigned magnitudes when they are captured.
// The unsigned core multiplies the magnitudes. The sign is applied once, to
// the final result.
//
// State table:
//   state  | meaning
//   S_IDLE | waiting for start; busy=0, done=0
//   S_RUN  | one shift-add iteration per clock; busy=1
//   S_DONE | single-cycle done pulse, product valid; start here re-enters RUN
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request, sampled only while busy=0
//   signed_mode  in   0 = unsigned, 1 = two's complement (captured with start)
//   a            in   WIDTH-bit multiplicand (captured with start)
//   b            in   WIDTH-bit multiplier (captured with start)
//   busy         out  high while a multiplication is in progress
//   done         out  one-cycle pulse when product is updated
//   product      out  2*WIDTH-bit result, holds until next completion or reset
// -----------------------------------------------------------------------------
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 neg_q,     neg_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_shift;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    always_comb begin
        // The most negative value negates to 2^(WIDTH-1). That still fits
        // as an unsigned WIDTH-bit magnitude.
        a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

        // The add into the upper half keeps its carry (WIDTH+1 bits). The
        // right shift then drops that carry into the accumulator MSB.
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_shift = {sum, acc_q[WIDTH-1:1]};

        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d    = acc_shift;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d   = S_DONE;
                    // A zero magnitude negates to zero, so no -0 can appear.
                    product_d = neg_q ? -acc_shift : acc_shift;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_param
//
// Testbench for seq_mult_param with directed vectors and hand-computed
// expected values.
//
// There is one WIDTH=8 instance for the directed scenarios. WIDTH=4 and
// WIDTH=16 instances take random operands. Their expected products come from
// the simulator's own signed or unsigned multiply.
//
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst;

    logic        start, sm;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] product;

    logic        start4, sm4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  prod4;

    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] prod16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    seq_mult_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    seq_mult_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16)
    );

    // Issue one request on the WIDTH=8 instance and wait for done, with a
    // bound on the wait. It returns on the done-cycle falling edge. lat is -1
    // on timeout. Operands are scrambled once start is dropped.
    task automatic run_op(input logic sm_i, input logic [7:0] a_i, input logic [7:0] b_i,
                          output int lat, output int busy_cycles);
        sm = sm_i; a = a_i; b = b_i; start = 1'b1;
        lat = -1; busy_cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; a = ~a_i; b = a_i ^ 8'h5A; sm = ~sm_i;
            end
            if (busy) busy_cycles++;
            if (done) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; a = 8'd5; b = 8'd5; sm = 1'b0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (product !== 16'h0000) $display("FAIL reset_product: got %h want 0000", product); else n_pass++;
        n_checks++; if (busy4 !== 1'b0 || busy16 !== 1'b0)
            $display("FAIL reset_busy_w4_w16: got %b %b want 0 0", busy4, busy16); else n_pass++;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_basic;
        int lat, bc;
        run_op(1'b0, 8'd13, 8'd11, lat, bc);
        n_checks++; if (lat !== 8) $display("FAIL basic_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (bc !== 8) $display("FAIL basic_busy_cycles: got %0d want 8", bc); else n_pass++;
        n_checks++; if (product !== 16'h008F) $display("FAIL basic_product: got %h want 008f", product); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b want 0", busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL basic_done_width: got %b want 0", done); else n_pass++;
        n_checks++; if (product !== 16'h008F) $display("FAIL basic_product_hold: got %h want 008f", product); else n_pass++;
    endtask

    task automatic test_directed;
        int lat, bc;
        logic        sm_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0]  a_v  [5] = '{8'hFF, 8'hFD, 8'h80, 8'h80, 8'h00};
        logic [7:0]  b_v  [5] = '{8'hFF, 8'h05, 8'h80, 8'h01, 8'h80};
        logic [15:0] p_v  [5] = '{16'hFE01, 16'hFFF1, 16'h4000, 16'hFF80, 16'h0000};
        for (int k = 0; k < 5; k++) begin
            run_op(sm_v[k], a_v[k], b_v[k], lat, bc);
            n_checks++; if (lat !== 8)
                $display("FAIL directed_latency[%0d]: got %0d want 8", k, lat); else n_pass++;
            n_checks++; if (product !== p_v[k])
                $display("FAIL directed_product[%0d]: got %h want %h", k, product, p_v[k]); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_and_back_to_back;
        int lat;
        int early_done;
        // The previous result (0x0000) must stay readable during the new run.
        sm = 1'b0; a = 8'd3; b = 8'd4; start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 2) begin
                n_checks++; if (product !== 16'h0000)
                    $display("FAIL prev_result_during_run: got %h want 0000", product); else n_pass++;
            end
            if (i == 3) begin start = 1'b1; a = 8'd7; b = 8'd7; end
            if (i == 4) start = 1'b0;
            if (done) begin lat = i - 1; break; end
        end
        n_checks++; if (lat !== 8) $display("FAIL ignore_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (product !== 16'h000C) $display("FAIL ignore_product: got %h want 000c", product); else n_pass++;

        // Start is held high in the done cycle, so RUN follows with no idle gap.
        start = 1'b1; a = 8'd2; b = 8'd5; sm = 1'b0;
        lat = -1; early_done = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; a = 8'hEE; b = 8'h99;
                n_checks++; if (busy !== 1'b1)
                    $display("FAIL b2b_no_gap: busy got %b want 1", busy); else n_pass++;
            end
            if (done) begin lat = i - 1; break; end
        end
        n_checks++; if (lat !== 8) $display("FAIL b2b_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (product !== 16'h000A) $display("FAIL b2b_product: got %h want 000a", product); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, dcount;
        run_op(1'b0, 8'd6, 8'd7, lat, bc);
        n_checks++; if (product !== 16'h002A) $display("FAIL pre_abort_product: got %h want 002a", product); else n_pass++;
        @(negedge clk);

        sm = 1'b0; a = 8'd9; b = 8'd9; start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else n_pass++;
        n_checks++; if (product !== 16'h0000) $display("FAIL abort_product: got %h want 0000", product); else n_pass++;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        n_checks++; if (dcount !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", dcount); else n_pass++;

        run_op(1'b0, 8'd9, 8'd9, lat, bc);
        n_checks++; if (lat !== 8) $display("FAIL after_abort_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (product !== 16'h0051) $display("FAIL after_abort_product: got %h want 0051", product); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random_w4;
        longint ea, eb, p;
        logic [7:0] exp_p;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            sm4 = 1'($urandom_range(0, 1));
            a4 = 4'($urandom); b4 = 4'($urandom);
            ea = sm4 ? longint'($signed(a4)) : longint'(a4);
            eb = sm4 ? longint'($signed(b4)) : longint'(b4);
            p = ea * eb;
            exp_p = p[7:0];
            start4 = 1'b1;
            lat = -1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (i == 1) begin start4 = 1'b0; a4 = ~a4; b4 = 4'($urandom); end
                if (done4) begin lat = i - 1; break; end
            end
            n_checks++; if (lat !== 4)
                $display("FAIL w4_latency[%0d]: got %0d want 4", n, lat); else n_pass++;
            n_checks++; if (prod4 !== exp_p)
                $display("FAIL w4_product[%0d]: sm=%b got %h want %h", n, sm4, prod4, exp_p); else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_random_w16;
        longint ea, eb, p;
        logic [31:0] exp_p;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            sm16 = 1'($urandom_range(0, 1));
            a16 = 16'($urandom); b16 = 16'($urandom);
            if (n == 0) begin sm16 = 1'b1; a16 = 16'h8000; b16 = 16'h8000; end
            if (n == 1) begin sm16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF; end
            ea = sm16 ? longint'($signed(a16)) : longint'(a16);
            eb = sm16 ? longint'($signed(b16)) : longint'(b16);
            p = ea * eb;
            exp_p = p[31:0];
            start16 = 1'b1;
            lat = -1;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (i == 1) begin start16 = 1'b0; a16 = ~a16; b16 = 16'($urandom); end
                if (done16) begin lat = i - 1; break; end
            end
            n_checks++; if (lat !== 16)
                $display("FAIL w16_latency[%0d]: got %0d want 16", n, lat); else n_pass++;
            n_checks++; if (prod16 !== exp_p)
                $display("FAIL w16_product[%0d]: sm=%b got %h want %h", n, sm16, prod16, exp_p); else n_pass++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_directed();
        test_ignore_and_back_to_back();
        test_reset_mid_run();
        test_random_w4();
        test_random_w16();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
